// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: decodes din[9:8] as a command
// on each rising edge of rx_valid, stores write data and returns read data for MISO.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_ARMED = 1'b1
  } rd_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rx_valid_q;
  rd_state_t            rd_state;

  logic [1:0] cmd;
  logic       cmd_stb;
  logic       wr_en;

  assign cmd     = din[9:8];
  assign cmd_stb = rx_valid & ~rx_valid_q;
  assign wr_en   = ~rst & cmd_stb & (cmd == CMD_WR_DATA) & wr_armed;

  // Storage is deliberately left out of reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // rx_valid_q resets high so a level held through reset is not a new command.
      rx_valid_q <= 1'b1;
      wr_addr    <= '0;
      rd_addr    <= '0;
      wr_armed   <= 1'b0;
      rd_state   <= RD_IDLE;
      dout       <= 8'h00;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      cmd_err    <= 1'b0;
      if (cmd_stb) begin
        // Any strobe other than a successful read drops tx_valid.
        tx_valid <= 1'b0;
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr  <= din[ADDR_SIZE-1:0];
            wr_armed <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_armed) begin
              wr_addr <= wr_addr + 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr  <= din[ADDR_SIZE-1:0];
            rd_state <= RD_ARMED;
          end
          CMD_RD_DATA: begin
            if (rd_state == RD_ARMED) begin
              dout     <= mem[rd_addr];
              tx_valid <= 1'b1;
              rd_state <= RD_IDLE;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl: one task per scenario, hand-computed expectations.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;

  int checks;
  int errors;

  spi_ram_ctrl #(.ADDR_SIZE(8), .MEM_DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .cmd_err  (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe: rx_valid high for one cycle then low; returns at the negedge after the executing edge.
  task automatic send_cmd(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    din      = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    din = 10'h000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", dout); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err got %b want 0", cmd_err); end
  endtask

  task automatic test_unarmed_write();
    send_cmd(2'b01, 8'h33);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL unarmed_wr_err got %b want 1", cmd_err); end
    @(negedge clk);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL unarmed_wr_err_pulse got %b want 0", cmd_err); end
    send_cmd(2'b10, 8'h00);
    send_cmd(2'b11, 8'h00);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL unarmed_rd_tx got %b want 1", tx_valid); end
    checks++; if (dout === 8'h33) begin errors++; $display("FAIL unarmed_rd_dout got %h want not 33", dout); end
  endtask

  task automatic test_read_unarmed();
    logic [7:0] prev;
    prev = dout;
    send_cmd(2'b11, 8'h00);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL rd_idle_err got %b want 1", cmd_err); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_tx got %b want 0", tx_valid); end
    checks++; if (dout !== prev) begin errors++; $display("FAIL rd_idle_dout got %h want %h", dout, prev); end
  endtask

  task automatic test_write_read();
    send_cmd(2'b00, 8'h12);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL wr_addr_err got %b want 0", cmd_err); end
    send_cmd(2'b01, 8'hA5);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL wr_data_err got %b want 0", cmd_err); end
    send_cmd(2'b10, 8'h12);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL wr_rd_dout got %h want a5", dout); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_tx got %b want 1", tx_valid); end
    repeat (4) @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_hold got %b want 1", tx_valid); end
    send_cmd(2'b10, 8'h12);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_clear got %b want 0", tx_valid); end
  endtask

  task automatic test_back_to_back();
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'hA5 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got dout=%h tx=%b want a5/1", dout, tx_valid);
    end
    send_cmd(2'b11, 8'h00);
    checks++; if (cmd_err !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second got err=%b tx=%b want 1/0", cmd_err, tx_valid);
    end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL b2b_dout got %h want a5", dout); end
  endtask

  task automatic test_burst_wrap();
    send_cmd(2'b00, 8'hFF);
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    send_cmd(2'b10, 8'hFF);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL wrap_ff got %h want 11", dout); end
    send_cmd(2'b10, 8'h00);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h22) begin errors++; $display("FAIL wrap_00 got %h want 22", dout); end
  endtask

  task automatic test_latest_addr();
    send_cmd(2'b10, 8'h12);
    send_cmd(2'b10, 8'hFF);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h11 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL latest_addr got dout=%h tx=%b want 11/1", dout, tx_valid);
    end
  endtask

  task automatic test_level();
    send_cmd(2'b00, 8'h05);
    @(negedge clk);
    din      = {2'b01, 8'h44};
    rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    send_cmd(2'b01, 8'h55);
    send_cmd(2'b10, 8'h05);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h44) begin errors++; $display("FAIL level_05 got %h want 44", dout); end
    send_cmd(2'b10, 8'h06);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h55) begin errors++; $display("FAIL level_06 got %h want 55", dout); end
  endtask

  task automatic test_reset_mid();
    send_cmd(2'b10, 8'h05);
    send_cmd(2'b11, 8'h00);
    checks++; if (tx_valid !== 1'b1 || dout !== 8'h44) begin
      errors++; $display("FAIL mid_pre got dout=%h tx=%b want 44/1", dout, tx_valid);
    end
    @(negedge clk);
    din      = {2'b00, 8'h20};
    rx_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (tx_valid !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL mid_rst got dout=%h tx=%b want 00/0", dout, tx_valid);
    end
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    send_cmd(2'b01, 8'h66);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL mid_held_ignored got err=%b want 1", cmd_err); end
    send_cmd(2'b10, 8'h05);
    send_cmd(2'b11, 8'h00);
    checks++; if (dout !== 8'h44 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL mid_retained got dout=%h tx=%b want 44/1", dout, tx_valid);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    din      = 10'h000;
    test_reset();
    test_unarmed_write();
    test_read_unarmed();
    test_write_read();
    test_back_to_back();
    test_burst_wrap();
    test_latest_addr();
    test_level();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit parallel words (`rx_data`/`rx_valid`) and decodes the two MSBs as a command. It stores write data and returns read data on `tx_data`/`tx_valid` for the slave to shift out on MISO. It also enforces command ordering and flags protocol violations.

## Interface
- `ADDR_SIZE`, default 8: address width; only `din[ADDR_SIZE-1:0]` is used as an address.
- `MEM_DEPTH`, default 256: number of words; always `2**ADDR_SIZE`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  10  word from the SPI slave; `[9:8]` is the command, `[7:0]` is the payload.
- `rx_valid`  in  1  level-valid from the slave; may stay high for several cycles per word.
- `dout`  out  8  read data (`tx_data` to the slave).
- `tx_valid`  out  1  `dout` holds valid read data.
- `cmd_err`  out  1  one-cycle pulse on an illegal command sequence.

## Operation
- Command strobe: `cmd_stb = rx_valid & ~rx_valid_q`, where `rx_valid_q` is `rx_valid` delayed by one cycle.
  - Exactly one command is executed per rising edge of `rx_valid`.
  - A level held high executes nothing further.
- Command decode on `cmd_stb`:
  - `00`: `wr_addr <= din[ADDR_SIZE-1:0]`; set `wr_armed`.
  - `01`: if `wr_armed`, write `mem[wr_addr] <= din[7:0]`, then `wr_addr <= wr_addr+1` (mod `MEM_DEPTH`, wraps `MEM_DEPTH-1 -> 0`). If not armed, the write is dropped and `cmd_err` pulses.
  - `10`: `rd_addr <= din[ADDR_SIZE-1:0]`; read FSM goes to `RD_ARMED`.
  - `11`:
    - In `RD_ARMED`: `dout <= mem[rd_addr]`, `tx_valid <= 1`, FSM goes to `RD_IDLE`.
    - In `RD_IDLE`: `cmd_err` pulses, `dout` is unchanged, `tx_valid` is forced to 0.
- Read FSM:
  - `RD_IDLE` on `10` goes to `RD_ARMED`.
  - `RD_ARMED` on `11` goes to `RD_IDLE`.
  - `RD_ARMED` on `10` stays in `RD_ARMED` with the new address; the latest address wins.
  - `00`/`01` do not affect the read FSM.
- Every read needs its own preceding `10`: two back-to-back `11` commands give data followed by an error.
- `tx_valid` behaviour:
  - Held high after a successful `11` so the slave can shift 8 bits out.
  - Cleared on the next `cmd_stb` of any command other than a successful `11`.
  - A successful `11` while `tx_valid=1` reloads `dout` and keeps `tx_valid=1` with no gap.
- `wr_armed` persists across writes to allow auto-increment bursts. Only `rst` clears it.
- Memory is a single-port array with one access per cycle. Reads and writes cannot collide because only one command executes per strobe.

## Timing
- Reset values:
  - Outputs: `dout=0`, `tx_valid=0`, `cmd_err=0`.
  - Internal: `wr_addr=0`, `rd_addr=0`, `wr_armed=0`, FSM=`RD_IDLE`, `rx_valid_q=1`.
- `rx_valid_q` resets to 1, so an `rx_valid` held high through reset release is not a new command. A fresh 0 -> 1 transition is required.
- Memory contents are not reset.
- Latency: all effects (`mem` write, address load, `dout`/`tx_valid`, `cmd_err`) land on the first rising clock edge at which `rx_valid=1` is sampled with `rx_valid_q=0`. They are visible the cycle after that edge.
- Write then read of the same address on the next strobe returns the new data (write-first ordering across strobes).
- `cmd_err` is high for exactly one cycle per offending strobe.
- Reset mid-operation (`rst` high on any edge):
  - All registers above return to their reset values that cycle, and any strobe that cycle is ignored.
  - An in-flight `tx_valid` drops at once.
- Minimum command spacing is 2 cycles (`rx_valid` high 1 cycle, low 1 cycle). Any longer level is allowed.

## Test plan
- Write then read: strobes `din=00_0x12`, `01_0xA5`, `10_0x12`, `11_xx` -> `dout=0xA5` and `tx_valid=1` one cycle after the 4th strobe; `tx_valid` stays high until the next strobe.
- Burst wrap: `00_0xFF`, `01_0x11`, `01_0x22`, then reads of addresses `0xFF` and `0x00` -> `0x11` and `0x22` (address wraps to 0).
- Ordering errors:
  - After reset, `01_0x33` -> `cmd_err` 1-cycle pulse; a later read of address 0 does not return `0x33`.
  - `11` without a preceding `10` -> `cmd_err` pulses, `tx_valid=0`.
- Level handling: hold `rx_valid` high 10 cycles with `01_0x44` after `00_0x05` -> exactly one write, and `wr_addr` advances once (next `01` lands at `0x06`).
- Reset mid-read: `10_0x05`, `11`, `tx_valid=1`, then `rst` for 1 cycle with `rx_valid` held high -> `tx_valid=0`, `dout=0`, no command executed until `rx_valid` toggles low then high; memory at `0x05` is retained.
